// File: rtl/core_instr_encoder.sv
// rtl/core_instr_encoder.sv - RV32I field-to-word encoder and instruction-RAM writer
//
// Purpose: accepts decoded RV32I fields over a valid/ready handshake, packs
// them into 32-bit instruction words (R/I/IZ/S/B/U/J formats) and writes the
// words to consecutive instruction-memory word addresses through a two-stage
// pipeline (S1 = captured fields, S2 = encoded word waiting for the memory).
//
// Optional feature: define ENCODER_RANGE_CHECK_EN to reject field sets whose
// immediate does not fit the selected format (dropped, o_err set).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_clear                    synchronous clear of counter, pipeline, flags
//   i_valid / o_ready          field-set handshake
//   i_opcode, i_funct3,
//   i_funct7, i_rd, i_rs1,
//   i_rs2, i_imm               decoded instruction fields
//   o_wr_en / i_wr_ready       memory write handshake
//   o_wr_addr, o_wr_data       word address and encoded instruction
//   o_err                      sticky: a field set was dropped
//   o_wrapped                  sticky: the address counter wrapped

module core_instr_encoder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_funct3,
    input  logic [6:0]            i_funct7,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_rs1,
    input  logic [4:0]            i_rs2,
    input  logic [31:0]           i_imm,
    output logic                  o_wr_en,
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [31:0]           o_wr_data,
    output logic                  o_err,
    output logic                  o_wrapped
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BXXX  = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALI   = 7'b0010011;
    localparam logic [6:0] OP_ALR   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_IZ, FMT_S, FMT_B, FMT_U, FMT_J, FMT_UNK
    } fmt_t;

    // S1: captured fields
    logic        s1_valid;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_funct3;
    logic [6:0]  s1_funct7;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    // S2: encoded word awaiting the memory
    logic                  s2_valid;
    logic [31:0]           s2_data;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic                  err_q;
    logic                  wrapped_q;

    fmt_t        fmt;
    logic        is_shift;
    logic [31:0] enc_word;
    logic        range_ok;
    logic        drop;
    logic        s1_move;
    logic        wr_done;
    logic        accept;

    always_comb begin
        fmt = FMT_UNK;
        case (s1_opcode)
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_JALR, OP_LOAD: fmt = FMT_I;
            OP_BXXX:          fmt = FMT_B;
            OP_STORE:         fmt = FMT_S;
            OP_ALR:           fmt = FMT_R;
            OP_ALI:           fmt = (s1_funct3 == 3'b011) ? FMT_IZ : FMT_I;
            default:          fmt = FMT_UNK;
        endcase
    end

    // Immediate shifts carry funct7 in the upper bits instead of imm[11:5].
    assign is_shift = (s1_opcode == OP_ALI) &&
                      ((s1_funct3 == 3'b001) || (s1_funct3 == 3'b101));

    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R:  enc_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_I, FMT_IZ: begin
                if (is_shift)
                    enc_word = {s1_funct7, s1_imm[4:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
                else
                    enc_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            end
            FMT_S:  enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B:  enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                                s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U:  enc_word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J:  enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                s1_rd, s1_opcode};
            default: enc_word = 32'h0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // An immediate fits N signed bits when bits [31:N-1] are all equal.
    logic sext12_ok;
    logic sext13_ok;
    logic sext21_ok;

    assign sext12_ok = (s1_imm[31:11] == '0) || (s1_imm[31:11] == '1);
    assign sext13_ok = (s1_imm[31:12] == '0) || (s1_imm[31:12] == '1);
    assign sext21_ok = (s1_imm[31:20] == '0) || (s1_imm[31:20] == '1);

    always_comb begin
        range_ok = 1'b1;
        case (fmt)
            FMT_I:   range_ok = is_shift ? (s1_imm[11:5] == '0) : sext12_ok;
            FMT_IZ:  range_ok = (s1_imm[31:12] == '0);
            FMT_S:   range_ok = sext12_ok;
            FMT_B:   range_ok = sext13_ok && !s1_imm[0];
            FMT_J:   range_ok = sext21_ok && !s1_imm[0];
            FMT_U:   range_ok = (s1_imm[11:0] == '0);
            default: range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    // A dropped set leaves S1 without needing room in S2.
    assign drop    = (fmt == FMT_UNK) || !range_ok;
    assign wr_done = s2_valid && i_wr_ready;
    assign s1_move = s1_valid && (drop || !s2_valid || i_wr_ready);
    assign o_ready = !i_clear && (!s1_valid || s1_move);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_opcode <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            addr_cnt  <= '0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (i_clear) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            addr_cnt  <= '0;
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            if (wr_done) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (&addr_cnt)
                    wrapped_q <= 1'b1;
            end

            // Refill and drain may happen on the same edge.
            if (s1_move && !drop) begin
                s2_valid <= 1'b1;
                s2_data  <= enc_word;
            end else if (wr_done) begin
                s2_valid <= 1'b0;
            end

            if (s1_move && drop)
                err_q <= 1'b1;

            if (accept) begin
                s1_valid  <= 1'b1;
                s1_opcode <= i_opcode;
                s1_funct3 <= i_funct3;
                s1_funct7 <= i_funct7;
                s1_rd     <= i_rd;
                s1_rs1    <= i_rs1;
                s1_rs2    <= i_rs2;
                s1_imm    <= i_imm;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

    assign o_wr_en   = s2_valid;
    assign o_wr_addr = addr_cnt;
    assign o_wr_data = s2_data;
    assign o_err     = err_q;
    assign o_wrapped = wrapped_q;

endmodule

// File: tb/tb_core_instr_encoder.sv
// tb/tb_core_instr_encoder.sv - directed vector bench for core_instr_encoder

module tb_core_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [6:0]    i_opcode = '0;
    logic [2:0]    i_funct3 = '0;
    logic [6:0]    i_funct7 = '0;
    logic [4:0]    i_rd = '0;
    logic [4:0]    i_rs1 = '0;
    logic [4:0]    i_rs2 = '0;
    logic [31:0]   i_imm = '0;
    logic          o_wr_en;
    logic          i_wr_ready = 1'b1;
    logic [AW-1:0] o_wr_addr;
    logic [31:0]   o_wr_data;
    logic          o_err;
    logic          o_wrapped;

    int checks = 0;
    int failures = 0;

    core_instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .o_wr_en(o_wr_en), .i_wr_ready(i_wr_ready),
        .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_err(o_err), .o_wrapped(o_wrapped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        wr;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        i_opcode = op; i_funct3 = f3; i_funct7 = f7;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    endtask

    task automatic do_clear();
        @(negedge clk);
        i_clear = 1'b1;
        #1 check("clear_ready_low", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        i_clear = 1'b0;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        do_clear();
        drive(v.op, v.f3, v.f7, v.rd, v.rs1, v.rs2, v.imm);
        i_valid = 1'b1;
        #1 check($sformatf("vec%0d_ready", idx), {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        #1;
        check($sformatf("vec%0d_wr_en", idx), {31'b0, o_wr_en}, {31'b0, v.wr});
        check($sformatf("vec%0d_err", idx), {31'b0, o_err}, {31'b0, !v.wr});
        if (v.wr) begin
            check($sformatf("vec%0d_data", idx), o_wr_data, v.word);
            check($sformatf("vec%0d_addr", idx), {30'b0, o_wr_addr}, 32'd0);
        end
    endtask

    // Streams n ADDI x1,x0,k+1 sets; i_wr_ready is low for cycles stall_lo..stall_hi.
    task automatic stream_addi(input int n, input int stall_lo, input int stall_hi);
        int k = 0;
        int w = 0;
        logic prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [AW-1:0] pa = '0;
        for (int c = 0; c < 40 && w < n; c++) begin
            @(negedge clk);
            i_wr_ready = !(c >= stall_lo && c <= stall_hi);
            i_valid = (k < n);
            drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(k + 1));
            #1;
            if (prev_stall) begin
                check("stall_wr_en_hold", {31'b0, o_wr_en}, 32'd1);
                check("stall_data_hold", o_wr_data, pd);
                check("stall_addr_hold", {30'b0, o_wr_addr}, {30'b0, pa});
            end
            if (c == stall_lo + 1)
                check("stall_ready_low", {31'b0, o_ready}, 32'd0);
            if (o_wr_en && i_wr_ready) begin
                check($sformatf("stream_w%0d_data", w), o_wr_data, (32'(w + 1) << 20) | 32'h93);
                check($sformatf("stream_w%0d_addr", w), {30'b0, o_wr_addr}, 32'(w % 4));
                check($sformatf("stream_w%0d_wrapped", w), {31'b0, o_wrapped}, {31'b0, (w >= 4)});
                w++;
            end
            prev_stall = o_wr_en && !i_wr_ready;
            pd = o_wr_data;
            pa = o_wr_addr;
            if (i_valid && o_ready)
                k++;
        end
        i_valid = 1'b0;
        i_wr_ready = 1'b1;
        check("stream_write_count", 32'(w), 32'(n));
    endtask

    initial begin
        vecs[0]  = '{7'h13, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd31, 32'h00000005, 1'b1, 32'h00500093};
        vecs[1]  = '{7'h6F, 3'd7, 7'h7F, 5'd1,  5'd31, 5'd31, 32'h00000008, 1'b1, 32'h008000EF};
        vecs[2]  = '{7'h63, 3'd0, 7'h7F, 5'd31, 5'd1,  5'd2,  32'hFFFFFFFC, 1'b1, 32'hFE208EE3};
        vecs[3]  = '{7'h37, 3'd7, 7'h7F, 5'd5,  5'd3,  5'd4,  32'h12345000, 1'b1, 32'h123452B7};
        vecs[4]  = '{7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'hFFFFFFFF, 1'b1, 32'h402081B3};
        vecs[5]  = '{7'h23, 3'd2, 7'h7F, 5'd31, 5'd1,  5'd2,  32'h00000008, 1'b1, 32'h0020A423};
        vecs[6]  = '{7'h13, 3'd5, 7'h20, 5'd1,  5'd2,  5'd31, 32'h00000003, 1'b1, 32'h40315093};
        vecs[7]  = '{7'h13, 3'd3, 7'h7F, 5'd1,  5'd2,  5'd31, 32'h000007FF, 1'b1, 32'h7FF13093};
        vecs[8]  = '{7'h03, 3'd2, 7'h7F, 5'd5,  5'd1,  5'd31, 32'hFFFFFFFC, 1'b1, 32'hFFC0A283};
        vecs[9]  = '{7'h67, 3'd0, 7'h7F, 5'd0,  5'd1,  5'd31, 32'h00000000, 1'b1, 32'h00008067};
        vecs[10] = '{7'h17, 3'd0, 7'h7F, 5'd2,  5'd31, 5'd31, 32'hFFFFF000, 1'b1, 32'hFFFFF117};
        vecs[11] = '{7'h6F, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFC, 1'b1, 32'hFFDFF06F};
        vecs[12] = '{7'h7F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00000005, 1'b0, 32'h00000000};
`ifdef ENCODER_RANGE_CHECK_EN
        vecs[13] = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00001000, 1'b0, 32'h00000000};
`else
        vecs[13] = '{7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00001000, 1'b1, 32'h00000093};
`endif
        vecs[14] = '{7'h63, 3'd1, 7'h00, 5'd0,  5'd3,  5'd4,  32'h00000010, 1'b1, 32'h00419863};

        // Reset state
        #12;
        check("rst_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_data", o_wr_data, 32'd0);
        check("rst_addr", {30'b0, o_wr_addr}, 32'd0);
        check("rst_err", {31'b0, o_err}, 32'd0);
        check("rst_wrapped", {31'b0, o_wrapped}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            apply_vec(i);

        // ADDI then JAL back to back: each written two edges after acceptance.
        do_clear();
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        i_valid = 1'b1;
        @(negedge clk);
        drive(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        #1 check("seq_lat_no_wr_yet", {31'b0, o_wr_en}, 32'd0);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("seq_addi_wr_en", {31'b0, o_wr_en}, 32'd1);
        check("seq_addi_data", o_wr_data, 32'h00500093);
        check("seq_addi_addr", {30'b0, o_wr_addr}, 32'd0);
        @(negedge clk);
        #1;
        check("seq_jal_data", o_wr_data, 32'h008000EF);
        check("seq_jal_addr", {30'b0, o_wr_addr}, 32'd1);
        @(negedge clk);
        #1;
        check("seq_idle_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("seq_idle_addr", {30'b0, o_wr_addr}, 32'd2);

        // Unknown opcode followed by ADDI.
        do_clear();
        drive(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        i_valid = 1'b1;
        @(negedge clk);
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("unk_no_write", {31'b0, o_wr_en}, 32'd0);
        check("unk_err", {31'b0, o_err}, 32'd1);
        @(negedge clk);
        #1;
        check("unk_addi_wr_en", {31'b0, o_wr_en}, 32'd1);
        check("unk_addi_data", o_wr_data, 32'h00500093);
        check("unk_addi_addr", {30'b0, o_wr_addr}, 32'd0);

        // Four ADDIs with a three-cycle memory stall.
        do_clear();
        stream_addi(4, 2, 4);

        // Five writes on a 2-bit counter wrap to address 0.
        do_clear();
        stream_addi(5, -5, -5);
        @(negedge clk);
        #1 check("wrap_sticky", {31'b0, o_wrapped}, 32'd1);

        // Asynchronous reset while a write is stalled.
        @(negedge clk);
        i_wr_ready = 1'b0;
        drive(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        i_valid = 1'b1;
        @(negedge clk);
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        #1;
        check("pre_rst_wr_en", {31'b0, o_wr_en}, 32'd1);
        check("pre_rst_data", o_wr_data, 32'h00900093);
        check("pre_rst_addr", {30'b0, o_wr_addr}, 32'd1);
        check("pre_rst_err", {31'b0, o_err}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("async_rst_data", o_wr_data, 32'd0);
        check("async_rst_addr", {30'b0, o_wr_addr}, 32'd0);
        check("async_rst_err", {31'b0, o_err}, 32'd0);
        check("async_rst_wrapped", {31'b0, o_wrapped}, 32'd0);
        check("async_rst_ready", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        i_wr_ready = 1'b1;

        // Clear abandons a pending write and ignores a same-cycle i_valid.
        @(negedge clk);
        i_wr_ready = 1'b0;
        drive(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        i_valid = 1'b1;
        @(negedge clk);
        drive(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
        @(negedge clk);
        @(negedge clk);
        #1 check("pre_clr_wr_en", {31'b0, o_wr_en}, 32'd1);
        i_clear = 1'b1;
        #1 check("clr_valid_ready_low", {31'b0, o_ready}, 32'd0);
        @(negedge clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_wr_ready = 1'b1;
        #1;
        check("clr_wr_en", {31'b0, o_wr_en}, 32'd0);
        check("clr_addr", {30'b0, o_wr_addr}, 32'd0);
        check("clr_err", {31'b0, o_err}, 32'd0);
        @(negedge clk);
        #1 check("clr_valid_ignored", {31'b0, o_wr_en}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
